// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift window over a raster pixel stream.
// Optional macro MATRIX_BORDER_EN: emit a window for every pixel with out-of-image taps forced to 0.
module matrix_3x3_gen #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ien,
    input  logic              sof,
    input  logic [DATA_W-1:0] idata,
    output logic [DATA_W-1:0] data11,
    output logic [DATA_W-1:0] data12,
    output logic [DATA_W-1:0] data13,
    output logic [DATA_W-1:0] data21,
    output logic [DATA_W-1:0] data22,
    output logic [DATA_W-1:0] data23,
    output logic [DATA_W-1:0] data31,
    output logic [DATA_W-1:0] data32,
    output logic [DATA_W-1:0] data33,
    output logic              oen
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     w_col_cur;
    logic [RW-1:0]     w_row_cur;
    logic [CW-1:0]     w_col_next;
    logic [RW-1:0]     w_row_next;
    logic              w_sof;

    logic [DATA_W-1:0] r_lb0 [0:IMG_W-1];
    logic [DATA_W-1:0] r_lb1 [0:IMG_W-1];
    logic [DATA_W-1:0] w_tap0;
    logic [DATA_W-1:0] w_tap1;

    logic [DATA_W-1:0] r_win [0:2][0:2];
    logic [DATA_W-1:0] w_row_in [0:2];
    logic [DATA_W-1:0] w_out [0:2][0:2];
    logic              r_oen;

    // A qualified sof forces the current pixel to (0,0) regardless of the counters.
    assign w_sof     = ien & sof;
    assign w_col_cur = w_sof ? '0 : r_col;
    assign w_row_cur = w_sof ? '0 : r_row;

    always_comb begin
        w_col_next = w_col_cur + CW'(1);
        w_row_next = w_row_cur;
        if (w_col_cur == CW'(IMG_W - 1)) begin
            w_col_next = '0;
            if (w_row_cur == RW'(IMG_H - 1)) begin
                w_row_next = '0;
            end else begin
                w_row_next = w_row_cur + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (ien) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // Line buffers are deliberately not reset; stale rows are never flagged valid.
    assign w_tap0 = r_lb0[w_col_cur];
    assign w_tap1 = r_lb1[w_col_cur];

    always_ff @(posedge clk) begin
        if (ien) begin
            r_lb1[w_col_cur] <= r_lb0[w_col_cur];
            r_lb0[w_col_cur] <= idata;
        end
    end

    assign w_row_in[0] = w_tap1;
    assign w_row_in[1] = w_tap0;
    assign w_row_in[2] = idata;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_win[gi][0] <= '0;
                    r_win[gi][1] <= '0;
                    r_win[gi][2] <= '0;
                end else if (ien) begin
                    r_win[gi][0] <= r_win[gi][1];
                    r_win[gi][1] <= r_win[gi][2];
                    r_win[gi][2] <= w_row_in[gi];
                end
            end
        end
    endgenerate

`ifdef MATRIX_BORDER_EN
    logic r_row_ge1;
    logic r_row_ge2;
    logic r_col_ge1;
    logic r_col_ge2;
    logic w_rmask [0:2];
    logic w_cmask [0:2];

    // Position flags of the pixel whose window is currently on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_ge1 <= 1'b0;
            r_row_ge2 <= 1'b0;
            r_col_ge1 <= 1'b0;
            r_col_ge2 <= 1'b0;
            r_oen     <= 1'b0;
        end else begin
            r_oen <= ien;
            if (ien) begin
                r_row_ge1 <= (w_row_cur >= RW'(1));
                r_row_ge2 <= (w_row_cur >= RW'(2));
                r_col_ge1 <= (w_col_cur >= CW'(1));
                r_col_ge2 <= (w_col_cur >= CW'(2));
            end
        end
    end

    assign w_rmask[0] = r_row_ge2;
    assign w_rmask[1] = r_row_ge1;
    assign w_rmask[2] = 1'b1;
    assign w_cmask[0] = r_col_ge2;
    assign w_cmask[1] = r_col_ge1;
    assign w_cmask[2] = 1'b1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_out_row
            for (genvar gj = 0; gj < 3; gj++) begin : g_out_col
                assign w_out[gi][gj] = (w_rmask[gi] && w_cmask[gj]) ? r_win[gi][gj] : '0;
            end
        end
    endgenerate
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oen <= 1'b0;
        end else begin
            r_oen <= ien && (w_row_cur >= RW'(2)) && (w_col_cur >= CW'(2));
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_out_row
            for (genvar gj = 0; gj < 3; gj++) begin : g_out_col
                assign w_out[gi][gj] = r_win[gi][gj];
            end
        end
    endgenerate
`endif

    assign data11 = w_out[0][0];
    assign data12 = w_out[0][1];
    assign data13 = w_out[0][2];
    assign data21 = w_out[1][0];
    assign data22 = w_out[1][1];
    assign data23 = w_out[1][2];
    assign data31 = w_out[2][0];
    assign data32 = w_out[2][1];
    assign data33 = w_out[2][2];
    assign oen    = r_oen;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen on a 4x4 image: frame-array model, per-cycle compare, literal window pins.
module tb_matrix_3x3_gen;

    localparam int DW = 10;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 9 * DW;

`ifdef MATRIX_BORDER_EN
    localparam int NWF   = 16;
    localparam int OFF22 = 10;
    localparam int NABRT = 6;
`else
    localparam int NWF   = 4;
    localparam int OFF22 = 0;
    localparam int NABRT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ien = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] idata = '0;
    logic [DW-1:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
    logic          oen;

    matrix_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .ien(ien), .sof(sof), .idata(idata),
        .data11(d11), .data12(d12), .data13(d13),
        .data21(d21), .data22(d22), .data23(d23),
        .data31(d31), .data32(d32), .data33(d33),
        .oen(oen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] dq[$];
    logic [PW-1:0] mq[$];
    logic [PW-1:0] s1q[$];
    logic [PW-1:0] dwin;

    assign dwin = {d11, d12, d13, d21, d22, d23, d31, d32, d33};

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int a, b, c, d, e, f, g, h, i);
        pk = {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
    endfunction

    // Model: remember every pixel by frame position; the window is read straight from that image.
    int pix [0:H-1][0:W-1];
    int mrow = 0, mcol = 0;
    logic [PW-1:0] ewin = '0;
    logic eoen = 1'b0;
    logic hv = 1'b1;

    initial begin
        logic s_rst, s_ien, s_sof;
        logic [DW-1:0] s_d;
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_ien = ien; s_sof = sof; s_d = idata;
            #1;
            if (!s_rst) begin
                mrow = 0; mcol = 0; ewin = '0; eoen = 1'b0; hv = 1'b1;
            end else if (s_ien) begin
                int r, c;
                r = s_sof ? 0 : mrow;
                c = s_sof ? 0 : mcol;
                pix[r][c] = int'(s_d);
                ewin = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        int rr, cc, v;
                        rr = r - 2 + i;
                        cc = c - 2 + j;
                        v = (rr < 0 || cc < 0) ? 0 : pix[rr][cc];
                        ewin = {ewin[PW-DW-1:0], DW'(v)};
                    end
                end
`ifdef MATRIX_BORDER_EN
                eoen = 1'b1;
`else
                eoen = (r >= 2) && (c >= 2);
`endif
                hv = eoen;
                c = c + 1;
                if (c == W) begin
                    c = 0;
                    r = (r == H - 1) ? 0 : r + 1;
                end
                mrow = r; mcol = c;
            end else begin
                eoen = 1'b0;
            end
            chk("oen", PW'(oen), PW'(eoen));
            if (eoen || hv) chk("window", dwin, ewin);
            if (oen) dq.push_back(dwin);
            if (eoen) mq.push_back(ewin);
        end
    end

    task automatic px(input int v, input bit s);
        @(negedge clk);
        ien = 1'b1; sof = s; idata = DW'(v);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            ien = 1'b0; sof = 1'b0;
        end
    endtask

    task automatic frame(input int base, input bit g);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                px(base + r * W + c, (r == 0) && (c == 0));
                if (g) gap(((r * W + c) % 2 == 0) ? 2 : int'($urandom_range(0, 2)));
            end
        end
    endtask

    task automatic clrq();
        dq.delete();
        mq.delete();
    endtask

    initial begin
        gap(2);
        @(negedge clk) rst_n = 1'b1;
        gap(1);

        // 1: continuous frame
        clrq();
        frame(0, 1'b0);
        gap(3);
        chk("s1_count", PW'(dq.size()), PW'(NWF));
        chk("s1_first", dq[OFF22], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chk("s1_last", dq[NWF-1], pk(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("s1_model_first", mq[OFF22], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chk("s1_model_last", mq[NWF-1], pk(5, 6, 7, 9, 10, 11, 13, 14, 15));
`ifdef MATRIX_BORDER_EN
        chk("s6_pix00", dq[0], pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("s6_pix11", dq[5], pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
        chk("s6_pix30", dq[12], pk(0, 0, 4, 0, 0, 8, 0, 0, 12));
        chk("s6_model_pix11", mq[5], pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
`else
        chk("s1_second", dq[1], pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chk("s1_third", dq[2], pk(4, 5, 6, 8, 9, 10, 12, 13, 14));
`endif
        s1q = dq;

        // 2: same frame with gaps
        clrq();
        frame(0, 1'b1);
        gap(3);
        chk("s2_count", PW'(dq.size()), PW'(NWF));
        for (int k = 0; k < NWF; k++) chk("s2_window", dq[k], s1q[k]);

        // 3: back-to-back frames
        clrq();
        frame(0, 1'b0);
        frame(100, 1'b0);
        gap(3);
        chk("s3_count", PW'(dq.size()), PW'(2 * NWF));
        chk("s3_f2_first", dq[NWF + OFF22], pk(100, 101, 102, 104, 105, 106, 108, 109, 110));

        // 4: frame aborted by sof at pixel 6
        clrq();
        for (int k = 0; k < 6; k++) px(k, k == 0);
        frame(0, 1'b0);
        gap(3);
        chk("s4_count", PW'(dq.size()), PW'(NABRT + NWF));
        chk("s4_first", dq[NABRT + OFF22], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chk("s4_last", dq[NABRT + NWF - 1], pk(5, 6, 7, 9, 10, 11, 13, 14, 15));

        // 5: reset pulse after pixel 11
        for (int k = 0; k < 12; k++) px(k, k == 0);
        @(negedge clk);
        ien = 1'b0; sof = 1'b0; rst_n = 1'b0;
        #1;
        chk("s5_rst_window", dwin, '0);
        chk("s5_rst_oen", PW'(oen), '0);
        gap(2);
        @(negedge clk) rst_n = 1'b1;
        clrq();
        gap(1);
        frame(0, 1'b0);
        gap(3);
        chk("s5_count", PW'(dq.size()), PW'(NWF));
        chk("s5_first", dq[OFF22], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
